// File: rtl/uart_tx_port_pkg.sv
// Shared types for the UART transmit port: FSM state encoding and status bit positions.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned HOLD_FULL_BIT = 0;
  localparam int unsigned BUSY_BIT      = 1;
  localparam int unsigned OVERRUN_BIT   = 2;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter timing one serial bit; tc_o is high while the count sits at zero.
module uart_baud_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: one holding register, one shifter, status register.
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frame instead of 10).
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter logic [31:0] ADDR         = 32'h0000_0000,
  parameter logic [31:0] STAT_ADDR    = 32'h0000_0004,
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [7:0]  wdata,
  input  logic        wen,
  output logic [7:0]  rdata,
  output logic        txd
);

  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

  tx_state_e   state_q;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic        overrun_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic        txd_q;

  logic        baud_tc;
  logic        baud_load;
  logic        wr_data;
  logic        wr_stat;
  logic        transfer;
  logic        accept;
  logic [7:0]  status;

  assign wr_data = wen && (addr == ADDR);
  assign wr_stat = wen && (addr == STAT_ADDR);

  // The holding byte leaves either from idle or at the end of a stop bit (back-to-back frames).
  assign transfer = hold_full_q &&
                    ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_tc));
  assign accept   = wr_data && (!hold_full_q || transfer);

  assign baud_load = (state_q == ST_IDLE) ? hold_full_q : baud_tc;

  uart_baud_cnt #(
    .WIDTH (16)
  ) u_baud_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (baud_load),
    .load_val_i (BIT_RELOAD),
    .tc_o       (baud_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (accept) begin
        hold_q      <= wdata;
        hold_full_q <= 1'b1;
      end else if (transfer) begin
        hold_full_q <= 1'b0;
      end
      if (wr_stat) begin
        overrun_q <= 1'b0;
      end else if (wr_data && !accept) begin
        overrun_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          txd_q <= 1'b1;
          if (hold_full_q) begin
            shift_q <= hold_q;
            state_q <= ST_START;
            txd_q   <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_tc) begin
            state_q   <= ST_DATA;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (baud_tc) begin
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= ST_PARITY;
              txd_q     <= ^shift_q;
`else
              state_q   <= ST_STOP;
              txd_q     <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= shift_q[bit_idx_q + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_tc) begin
            state_q <= ST_STOP;
            txd_q   <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (baud_tc) begin
            if (hold_full_q) begin
              shift_q <= hold_q;
              state_q <= ST_START;
              txd_q   <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              txd_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    status                = '0;
    status[HOLD_FULL_BIT] = hold_full_q;
    status[BUSY_BIT]      = (state_q != ST_IDLE);
    status[OVERRUN_BIT]   = overrun_q;
    rdata = (addr == STAT_ADDR) ? status : 8'h00;
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: directed scenarios plus random bus traffic against a line-queue model.
// The model turns each accepted byte into a queue of per-cycle txd levels.
module tb_uart_tx_port;

  localparam int          N       = 4;
  localparam logic [31:0] TX_ADDR = 32'h0000_0000;
  localparam logic [31:0] ST_ADDR = 32'h0000_0004;
`ifdef UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
`else
  localparam int          FRAME_BITS = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [7:0]  wdata;
  logic        wen;
  logic [7:0]  rdata;
  logic        txd;

  int assertCount = 0;
  int failCount   = 0;
  int cycleNo     = 0;

  bit         lineQ[$];
  logic       modelHoldV;
  logic [7:0] modelHoldD;
  logic       modelOvr;
  logic       modelTxd;
  logic       modelBusy;

  always #5 clk = ~clk;

  uart_tx_port #(
    .ADDR         (TX_ADDR),
    .STAT_ADDR    (ST_ADDR),
    .CLKS_PER_BIT (N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .wen   (wen),
    .rdata (rdata),
    .txd   (txd)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycleNo, observed, expected);
    end
  endtask

  function automatic logic [7:0] expRdata(input logic [31:0] a);
    if (a == ST_ADDR) return {5'b0, modelOvr, modelBusy, modelHoldV};
    return 8'h00;
  endfunction

  // Append one complete frame to the line queue, each bit held for N cycles.
  task automatic pushFrame(input logic [7:0] d);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k < N; k++) lineQ.push_back(bits[i]);
    end
  endtask

  task automatic modelEdge(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d);
    logic xfer;
    if (r) begin
      lineQ.delete();
      modelHoldV = 1'b0;
      modelHoldD = 8'h00;
      modelOvr   = 1'b0;
      modelTxd   = 1'b1;
      modelBusy  = 1'b0;
      return;
    end
    xfer = (lineQ.size() == 0) && modelHoldV;
    if (xfer) begin
      pushFrame(modelHoldD);
      modelHoldV = 1'b0;
    end
    if (w && a == TX_ADDR) begin
      if (!modelHoldV) begin
        modelHoldV = 1'b1;
        modelHoldD = d;
      end else begin
        modelOvr = 1'b1;
      end
    end
    if (w && a == ST_ADDR) modelOvr = 1'b0;
    if (lineQ.size() > 0) begin
      modelTxd  = lineQ.pop_front();
      modelBusy = 1'b1;
    end else begin
      modelTxd  = 1'b1;
      modelBusy = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d);
    reset = r;
    wen   = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    cycleNo++;
    modelEdge(r, w, a, d);
    #1;
    checkOutput("txd", {31'b0, txd}, {31'b0, modelTxd});
    checkOutput("rdata", {24'b0, rdata}, {24'b0, expRdata(a)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, ST_ADDR, 8'h00);
  endtask

  task automatic writeTx(input logic [7:0] d);
    applyStimulus(1'b0, 1'b1, TX_ADDR, d);
  endtask

  initial begin
    int busyCnt;
    logic [31:0] a;
    reset = 1'b1;
    wen   = 1'b0;
    addr  = ST_ADDR;
    wdata = 8'h00;

    applyStimulus(1'b1, 1'b0, ST_ADDR, 8'h00);
    applyStimulus(1'b1, 1'b0, ST_ADDR, 8'h00);
    checkOutput("reset_txd", {31'b0, txd}, 32'd1);
    checkOutput("reset_rdata", {24'b0, rdata}, 32'h00);
    idle(3);

    // Single frame from idle.
    writeTx(8'hA5);
    idle(4 * FRAME_BITS + 5);

    // Second byte queued while the first is still shifting: no gap, no overrun.
    writeTx(8'h55);
    idle(15);
    writeTx(8'h0F);
    idle(2 * 4 * FRAME_BITS + 5);
    checkOutput("back2back_overrun", {31'b0, rdata[2]}, 32'd0);

    // Three consecutive writes: third one is dropped and flags overrun.
    writeTx(8'h11);
    writeTx(8'h22);
    writeTx(8'h33);
    idle(1);
    checkOutput("overrun_status", {24'b0, rdata}, 32'h07);
    applyStimulus(1'b0, 1'b1, ST_ADDR, 8'hFF);
    checkOutput("overrun_clear", {24'b0, rdata}, 32'h03);
    idle(2 * 4 * FRAME_BITS + 5);

    // Reset during data bit 3 aborts the frame.
    writeTx(8'h9C);
    idle(18);
    applyStimulus(1'b1, 1'b0, ST_ADDR, 8'h00);
    checkOutput("abort_txd", {31'b0, txd}, 32'd1);
    checkOutput("abort_rdata", {24'b0, rdata}, 32'h00);
    idle(60);

    // Write on the exact transfer cycle is accepted.
    writeTx(8'h3C);
    writeTx(8'hC3);
    idle(1);
    checkOutput("xfer_write_status", {24'b0, rdata}, 32'h03);
    idle(2 * 4 * FRAME_BITS + 5);

    // Frame length measured by the busy flag.
    writeTx(8'h07);
    busyCnt = 0;
    for (int i = 0; i < 4 * FRAME_BITS + 20; i++) begin
      idle(1);
      if (rdata[1] === 1'b1) busyCnt++;
    end
    checkOutput("frame_len", busyCnt, 4 * FRAME_BITS);

    // Random bus traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = TX_ADDR;
        2:       a = ST_ADDR;
        default: a = $urandom;
      endcase
      applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 11) == 0, a, 8'($urandom));
    end
    idle(4 * FRAME_BITS * 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_port.md
UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 Parameter ADDR, default 32'h0000_0000: byte address of the transmit data register.
REQ-002 Parameter STAT_ADDR, default 32'h0000_0004: byte address of the status register.
REQ-003 Parameter CLKS_PER_BIT, default 104: clk cycles per serial bit, legal range 2..65535.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: reset is synchronous and active-high.
REQ-006 Port addr, input, 32: bus byte address, compared on all 32 bits.
REQ-007 Port wdata, input, 8: bus write data, low byte of the CPU word.
REQ-008 Port wen, input, 1: bus write strobe, one-cycle qualified.
REQ-009 Port rdata, output, 8: status read data, combinational, valid when addr == STAT_ADDR, else 8'h00.
REQ-010 Port txd, output, 1: serial line, idle high, registered.

Function
REQ-011 Write: wen && addr == ADDR with holding register empty SHALL load wdata into the holding register and set hold_full on the next edge.
REQ-012 Write to ADDR while hold_full = 1 SHALL be dropped and SHALL set the sticky overrun flag.
REQ-013 wen && addr == STAT_ADDR SHALL clear overrun, regardless of wdata.
REQ-014 rdata SHALL be {5'b0, overrun, busy, hold_full}; busy = FSM not in IDLE.
REQ-015 FSM states: IDLE, START, DATA, PARITY (configuration-dependent), STOP.
REQ-016 IDLE -> START when hold_full = 1: holding byte moves to the shift register and hold_full clears on the same edge; txd = 0 from the next cycle.
REQ-017 START, each DATA bit, PARITY and STOP SHALL each last exactly CLKS_PER_BIT cycles, timed by a bit counter that reloads on every state or bit change.
REQ-018 DATA SHALL send 8 bits LSB first; a 3-bit index runs 0..7, then the FSM leaves DATA.
REQ-019 STOP drives txd = 1; at its end the FSM goes to START directly if hold_full = 1 (back-to-back frames, no idle gap), else to IDLE.
REQ-020 A write accepted while the shifter is busy SHALL wait in the holding register; the frame in flight SHALL NOT be disturbed.
REQ-021 A write on the same cycle the holding byte transfers to the shifter SHALL be accepted (the holding register is seen as freeing), not flagged as overrun.

Reset
REQ-022 While reset = 1, on each clk edge: FSM = IDLE, txd = 1, hold_full = 0, overrun = 0, bit counter and bit index = 0.
REQ-023 Reset mid-frame SHALL abort the frame; txd is high from the edge after reset is sampled, and the holding byte is discarded.

Configuration
REQ-024 Macro UART_TX_PARITY_EN defined: PARITY state is inserted between DATA and STOP and sends the even-parity bit (XOR of the 8 data bits); the frame is 11 bits.
REQ-025 Macro undefined: PARITY state and its logic are absent; DATA goes directly to STOP; the frame is 10 bits.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding typedef and the status bit-position constants (HOLD_FULL_BIT = 0, BUSY_BIT = 1, OVERRUN_BIT = 2).
REQ-027 One sub-module, uart_baud_cnt (loadable down-counter with a terminal-count pulse), SHALL time each bit; the FSM, holding register and bus decode stay in uart_tx_port.

Verification (bench uses CLKS_PER_BIT = 4)
REQ-028 Write 8'hA5 to ADDR from idle -> txd low for 4 cycles starting 1 cycle after the write, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; rdata shows busy = 1 for the whole frame.
REQ-029 Write 8'h55, then 8'h0F while the first is in DATA -> the 8'h0F start bit follows the 8'h55 stop bit with no idle cycle; overrun stays 0.
REQ-030 Write 8'h11, 8'h22, 8'h33 on consecutive cycles -> 8'h11 and 8'h22 are sent; 8'h33 is dropped; rdata = 8'h07 during the 8'h11 frame; a write to STAT_ADDR clears bit 2.
REQ-031 Assert reset for 1 cycle during bit 3 of a frame -> txd = 1 and rdata = 8'h00 on the next cycle; no further frame is sent.
REQ-032 With UART_TX_PARITY_EN defined, write 8'h07 -> parity bit = 1, frame lasts 44 cycles; with the macro undefined, the same write gives a 40-cycle frame.
REQ-033 Write to ADDR on the exact cycle the holding byte transfers to the shifter -> write accepted, hold_full = 1 next cycle, overrun = 0.
